// File: rtl/uart_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module   : uart_pkg
// | Brief    : Shared types, constants and divider helper for the UART receiver.
// | Revision : 1.0
// +-----------------------------------------------------------------------------
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_rx_state_e;

  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module   : sync_2ff
// | Brief    : Two-flop synchronizer for asynchronous inputs, configurable reset value.
// | Revision : 1.0
// +-----------------------------------------------------------------------------
module sync_2ff #(
  parameter int unsigned           WIDTH   = 1,
  parameter logic [WIDTH-1:0]      RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module   : uart_rx
// | Brief    : 8-bit UART receiver, mid-bit sampling, one-entry valid/ready holding
// |            register, framing/overrun pulses. UART_RX_PARITY_EN adds even parity.
// | Revision : 1.0
// +-----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100000000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                      parity_err,
`endif
  output logic                      overrun
);

  localparam int unsigned     DIV     = calc_div(CLK_HZ, BAUD);
  localparam int unsigned     CW      = $clog2(DIV);
  localparam logic [CW-1:0]   HALF_M1 = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0]   FULL_M1 = CW'(DIV - 1);
  localparam logic [2:0]      LAST_BIT = 3'(UART_DATA_BITS - 1);

  if (DIV < 4) begin : g_div_check
    $error("uart_rx: CLK_HZ/BAUD must be at least 4");
  end

  logic                      rx_s;
  uart_rx_state_e            state_q;
  logic [CW-1:0]             cnt_q;
  logic [2:0]                bidx_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic                      rx_prev_q;
  logic                      done_q;
  logic [UART_DATA_BITS-1:0] rx_data_q;
  logic                      rx_valid_q;
  logic                      frame_err_q;
  logic                      overrun_q;
`ifdef UART_RX_PARITY_EN
  logic                      parity_err_q;
  logic                      par_bad_q;
`endif

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bidx_q      <= '0;
      shift_q     <= '0;
      rx_prev_q   <= 1'b1;
      done_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
      par_bad_q    <= 1'b0;
`endif
    end else begin
      rx_prev_q   <= rx_s;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif

      // A byte finished last cycle: a same-cycle consume frees the slot for it.
      if (done_q) begin
        if (!rx_valid_q || rx_ready) begin
          rx_data_q  <= shift_q;
          rx_valid_q <= 1'b1;
        end else begin
          overrun_q  <= 1'b1;
        end
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (!rx_s && rx_prev_q) begin
            state_q <= START;
            cnt_q   <= '0;
          end
        end
        START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q <= '0;
            if (!rx_s) begin
              state_q <= DATA;
              bidx_q  <= '0;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (cnt_q == FULL_M1) begin
            cnt_q   <= '0;
            shift_q <= {rx_s, shift_q[UART_DATA_BITS-1:1]};
            bidx_q  <= bidx_q + 3'd1;
            if (bidx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_q == FULL_M1) begin
            cnt_q        <= '0;
            state_q      <= STOP;
            par_bad_q    <= ^{shift_q, rx_s};
            parity_err_q <= ^{shift_q, rx_s};
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
`endif
        STOP: begin
          if (cnt_q == FULL_M1) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            if (!rx_s) begin
              frame_err_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (!par_bad_q) begin
`else
            end else begin
`endif
              done_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module   : tb_uart_rx
// | Brief    : Self-checking bench for uart_rx at DIV=16 (event-scheduled model).
// | Revision : 1.0
// +-----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int unsigned CLK_HZ = 100_000_000;
  localparam int unsigned BAUD   = 6_250_000;
  localparam int          DIV    = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif
  // Stop sample lands DIV/2 + (9 or 10)*DIV after START entry, START entry 3 after the fall.
  localparam int LAT_STOP = PAR_ON ? 3 + 8 + 10 * DIV : 3 + 8 + 9 * DIV;
  localparam int LAT_DONE = LAT_STOP + 1;
  localparam int LAT_PAR  = 3 + 8 + 9 * DIV;
  localparam int K_DONE = 0, K_FERR = 1, K_PERR = 2;

  typedef struct {
    int         at;
    int         kind;
    logic [7:0] d;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int         n_checks;
  int         n_errs;
  int         cyc;
  bit         cmp_en;
  ev_t        ev_q[$];
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ferr, m_ovr, m_perr;

  task automatic report(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_errs++;
    if (n_errs <= 40)
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) report(nm, {7'd0, act}, {7'd0, exp});
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) report(nm, act, exp);
  endtask

  task automatic push_ev(input int at, input int kind, input logic [7:0] d);
    ev_t e;
    e.at = at; e.kind = kind; e.d = d;
    ev_q.push_back(e);
  endtask

  // Model: frame outcomes are scheduled at absolute cycles; holding register follows valid/ready rules.
  task automatic model_run();
    bit         hit;
    logic [7:0] hd;
    forever begin
      @(posedge clk);
      cyc++;
      hit = 1'b0; hd = 8'h00;
      m_ferr = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
      if (!rst_n) begin
        m_valid = 1'b0; m_data = 8'h00;
        ev_q.delete();
      end else begin
        for (int i = ev_q.size() - 1; i >= 0; i--) begin
          if (ev_q[i].at == cyc) begin
            if (ev_q[i].kind == K_DONE) begin hit = 1'b1; hd = ev_q[i].d; end
            else if (ev_q[i].kind == K_FERR) m_ferr = 1'b1;
            else m_perr = 1'b1;
          end
          if (ev_q[i].at <= cyc) ev_q.delete(i);
        end
        if (hit) begin
          if (!m_valid || rx_ready) begin m_valid = 1'b1; m_data = hd; end
          else m_ovr = 1'b1;
        end else if (m_valid && rx_ready) begin
          m_valid = 1'b0;
        end
      end
    end
  endtask

  task automatic compare_run();
    forever begin
      @(negedge clk);
      if (rst_n && cmp_en) begin
        chk1("m_valid", rx_valid, m_valid);
        chk8("m_data", rx_data, m_data);
        chk1("m_frame_err", frame_err, m_ferr);
        chk1("m_overrun", overrun, m_ovr);
`ifdef UART_RX_PARITY_EN
        chk1("m_parity_err", parity_err, m_perr);
`endif
      end
    end
  endtask

  // Called just after a posedge; every bit lasts DIV cycles.
  task automatic drive_bit(input logic b);
    rx = b;
    repeat (DIV) @(posedge clk);
    #1;
  endtask

  // par < 0 means the correct even-parity bit (when parity is built in).
  task automatic send(input logic [7:0] d, input logic stop, input int par);
    int   f;
    logic pb;
    bit   bad;
    f   = cyc;
    pb  = (par < 0) ? ^d : par[0];
    bad = PAR_ON && ((^d) != pb);
    if (bad) push_ev(f + LAT_PAR, K_PERR, d);
    if (!stop) push_ev(f + LAT_STOP, K_FERR, d);
    else if (!bad) push_ev(f + LAT_DONE, K_DONE, d);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PAR_ON) drive_bit(pb);
    drive_bit(stop);
  endtask

  task automatic at_cyc(input int n);
    do @(negedge clk); while (cyc < n);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f;
    m_valid = 1'b0; m_data = 8'h00; m_ferr = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
    fork
      model_run();
      compare_run();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst_valid", rx_valid, 1'b0);
    chk8("rst_data", rx_data, 8'h00);
    chk1("rst_ferr", frame_err, 1'b0);
    chk1("rst_ovr", overrun, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cmp_en = 1'b1;
    idle(5);

    // 0x55, consumer always ready
    rx_ready = 1'b1;
    f = cyc;
    fork
      send(8'h55, 1'b1, -1);
      begin
        at_cyc(f + LAT_STOP);  chk1("t55_early", rx_valid, 1'b0);
        at_cyc(f + LAT_DONE);  chk1("t55_valid", rx_valid, 1'b1);
        chk8("t55_data", rx_data, 8'h55);
        chk1("t55_ferr", frame_err, 1'b0);
        at_cyc(f + LAT_DONE + 1); chk1("t55_consumed", rx_valid, 1'b0);
      end
    join

    // 0xA5 then 0x3C back-to-back, nobody consuming
    idle(10);
    rx_ready = 1'b0;
    send(8'hA5, 1'b1, -1);
    f = cyc;
    fork
      send(8'h3C, 1'b1, -1);
      begin
        at_cyc(f + LAT_DONE);
        chk1("ovr_pulse", overrun, 1'b1);
        chk8("ovr_data", rx_data, 8'hA5);
        chk1("ovr_valid", rx_valid, 1'b1);
      end
    join
    idle(20);
    rx_ready = 1'b1;
    idle(1);
    rx_ready = 1'b0;
    @(negedge clk);
    chk1("drain_valid", rx_valid, 1'b0);
    chk8("drain_data", rx_data, 8'hA5);

    // 6-cycle glitch, then 0x00
    idle(10);
    rx = 1'b0;
    idle(6);
    rx = 1'b1;
    idle(40);
    rx_ready = 1'b1;
    f = cyc;
    fork
      send(8'h00, 1'b1, -1);
      begin
        at_cyc(f + LAT_DONE);
        chk1("t00_valid", rx_valid, 1'b1);
        chk8("t00_data", rx_data, 8'h00);
      end
    join

    // 0xFF with a low stop bit, then 0x12
    idle(10);
    f = cyc;
    fork
      send(8'hFF, 1'b0, -1);
      begin
        at_cyc(f + LAT_STOP);     chk1("fe_pulse", frame_err, 1'b1);
        at_cyc(f + LAT_STOP + 1); chk1("fe_end", frame_err, 1'b0);
        chk1("fe_novalid", rx_valid, 1'b0);
      end
    join
    rx = 1'b1;
    idle(20);
    rx_ready = 1'b0;
    f = cyc;
    fork
      send(8'h12, 1'b1, -1);
      begin
        at_cyc(f + LAT_DONE);
        chk1("t12_valid", rx_valid, 1'b1);
        chk8("t12_data", rx_data, 8'h12);
      end
    join

    // Reset in the middle of data bit 4 of 0x81 while 0x12 is still held
    idle(10);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    rx = 1'b0;
    idle(8);
    rst_n = 1'b0;
    #1;
    chk1("amid_valid", rx_valid, 1'b0);
    chk8("amid_data", rx_data, 8'h00);
    chk1("amid_ferr", frame_err, 1'b0);
    chk1("amid_ovr", overrun, 1'b0);
    rx = 1'b1;
    idle(3);
    rst_n = 1'b1;
    idle(10);
    rx_ready = 1'b1;
    f = cyc;
    fork
      send(8'h7E, 1'b1, -1);
      begin
        at_cyc(f + LAT_DONE);
        chk1("t7e_valid", rx_valid, 1'b1);
        chk8("t7e_data", rx_data, 8'h7E);
      end
    join

`ifdef UART_RX_PARITY_EN
    idle(10);
    f = cyc;
    fork
      send(8'h07, 1'b1, 0);
      begin
        at_cyc(f + LAT_PAR);  chk1("par_bad_pulse", parity_err, 1'b1);
        at_cyc(f + LAT_DONE); chk1("par_bad_novalid", rx_valid, 1'b0);
      end
    join
    idle(10);
    f = cyc;
    fork
      send(8'h07, 1'b1, 1);
      begin
        at_cyc(f + LAT_DONE);
        chk1("par_ok_valid", rx_valid, 1'b1);
        chk8("par_ok_data", rx_data, 8'h07);
      end
    join
`endif

    idle(20);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Synthesizable 8-bit UART receiver: far end of the SoC `uart_tx` line.
- Two uses: instantiated in `tb_top` to decode and check console output from `soc_top`, and available as an SoC peripheral for host-to-board input.
- Fixed-divider bit timing, mid-bit sampling, 2-FF input synchronizer, one-entry holding register with valid/ready output handshake.
- Reports framing and overrun errors.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- BAUD, 115200, line rate. Localparam DIV = CLK_HZ/BAUD (truncating). Elaboration error if DIV < 4.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- rx  in  1  serial line, idle high, asynchronous to clk.
- rx_data  out  8  received byte, stable while rx_valid=1.
- rx_valid  out  1  byte available. Held until consumed.
- rx_ready  in  1  consumer accepts; transfer on rx_valid&&rx_ready at posedge.
- frame_err  out  1  one-cycle pulse: stop bit sampled 0.
- overrun  out  1  one-cycle pulse: byte completed while holding register full and not drained.

Behaviour:
- Reset values: sync FFs=1, state=IDLE, counters=0, rx_data=0, rx_valid=0, frame_err=0, overrun=0. Reset mid-frame aborts the frame with no error pulse.
- Synchronizer: rx -> s1 -> s2 (rx_s). The edge detector keeps a one-cycle delayed copy rx_d.
- Bit counter: cnt, width $clog2(DIV). Bit index: bidx, 3 bits.
- IDLE: on rx_s=0 && rx_d=1 -> START, cnt=0. A line held low never re-arms; a falling edge is required.
- START: cnt increments each cycle. At cnt==DIV/2-1:
  - rx_s=0 -> DATA, cnt=0, bidx=0.
  - rx_s=1 -> IDLE (glitch reject, no flag).
- DATA: at cnt==DIV-1, shift rx_s into the MSB of the shift register (LSB-first line order), cnt=0, bidx++.
  - After bidx 7 -> STOP, or PARITY if the macro is enabled.
- STOP: at cnt==DIV-1, sample rx_s and go to IDLE.
  - rx_s=1: byte complete.
  - rx_s=0: frame_err=1 for one cycle, byte discarded.
- Stop sample point: DIV/2 + 9*DIV cycles after START entry. START entry is 3 cycles after rx falls (2 sync + edge).
- Byte complete, resolved in the next posedge:
  - Holding register empty, or rx_valid&&rx_ready in the same cycle: load rx_data, rx_valid=1. Back-to-back consume-and-load keeps rx_valid=1.
  - Otherwise: overrun=1 for one cycle, new byte dropped, old rx_data/rx_valid unchanged.
- rx_valid&&rx_ready with no completing byte: rx_valid=0 next cycle. rx_data keeps its last value.
- frame_err and overrun never assert in the same cycle; the dropped byte is the only completion that cycle.
- rx_data must not change while rx_valid=1 except on a handshake.

Optional Feature:
- Macro: UART_RX_PARITY_EN, defined in defines.vh.
- Defined:
  - Adds PARITY state after DATA, sampled at cnt==DIV-1. Even parity over data bits plus parity bit.
  - Adds output port parity_err (1 bit, reset 0), one-cycle pulse on mismatch.
  - Byte is discarded on mismatch; the stop bit is still sampled and may also flag frame_err.
  - Stop sample point moves to DIV/2 + 10*DIV.
- Undefined: no PARITY state, no parity_err port, pure 8N1.

Decomposition:
- Package uart_pkg:
  - UART_DATA_BITS=8.
  - State enum uart_rx_state_e {IDLE, START, DATA, PARITY, STOP}, 3-bit encoding. PARITY is unused when the macro is off.
  - Function calc_div(clk_hz, baud).
- One natural sub-module: sync_2ff (parameterized reset value, here 1), reusable for btn/sw inputs.

Test Plan:
- CLK_HZ=100e6, BAUD=6.25e6 (DIV=16), 10 ns clock as in tb_top. Send 0x55 8N1, rx_ready=1 -> rx_valid high one cycle, rx_data=0x55, asserted 3+8+144+1 cycles after rx fall, no error pulses.
- rx_ready=0, send 0xA5 then 0x3C back-to-back -> rx_data=0xA5 held, overrun pulse at second stop sample. Then rx_ready=1 for one cycle -> rx_valid=0.
- 6-cycle low glitch on idle rx -> no rx_valid, state back to IDLE. Then send 0x00 -> rx_data=0x00 received.
- Send 0xFF with stop bit forced 0 -> frame_err pulse, no rx_valid. Line returns high, then send 0x12 -> rx_data=0x12.
- Assert rst_n=0 during data bit 4 of 0x81 -> all outputs 0 within the same cycle, no error. After release, send 0x7E -> received correctly.
- With UART_RX_PARITY_EN: send 0x07 with parity bit 0 -> parity_err pulse, no rx_valid. Send 0x07 with parity bit 1 -> rx_data=0x07.
